// File: rtl/if_stage_pkg.sv
// Shared fetch-stage types and constants for the instruction aligner.
package if_stage_pkg;

    typedef enum logic [1:0] {
        ALIGN     = 2'd0,
        SPAN_WAIT = 2'd1,
        SPAN_DONE = 2'd2
    } aligner_state_e;

    // Low two bits of a halfword that mark a full 32-bit instruction.
    localparam logic [1:0] RVC_OPCODE_FULL = 2'b11;

endpackage

// File: rtl/if_instr_aligner_rvc_length_decoder.sv
// RVC length decoder: flags a 16-bit halfword as the start of a compressed instruction.
module rvc_length_decoder
    import if_stage_pkg::*;
(
    input  logic [15:0] i_halfword,
    output logic        o_is_compressed
);

    assign o_is_compressed = (i_halfword[1:0] != RVC_OPCODE_FULL);

endmodule

// File: rtl/if_instr_aligner.sv
// Fetch-word instruction aligner; halfword alignment and 32-bit spanning are
// enabled by macro FROST_C_EXT_EN, otherwise every fetch word is one instruction.
module if_instr_aligner
    import if_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_stall,
    input  logic            i_flush,
    input  logic            i_holdoff,
    input  logic [XLEN-1:0] i_pc_reg,
    input  logic [31:0]     i_fetch_word,
    output logic [31:0]     o_instr,
    output logic            o_instr_valid,
    output logic            o_is_compressed,
    output logic            o_is_compressed_r,
    output logic            o_is_32bit_spanning,
    output logic            o_spanning_wait_for_fetch,
    output logic            o_spanning_in_progress,
    output logic            o_spanning_to_halfword,
    output logic            o_spanning_to_halfword_registered
);

`ifdef FROST_C_EXT_EN

    aligner_state_e r_state;
    logic [15:0]    r_span_lo;
    logic           r_is_compressed;
    logic           r_to_halfword;

    logic w_lo_compressed;
    logic w_hi_compressed;
    logic w_kill;
    logic w_unused;

    assign w_kill   = i_reset | i_flush;
    assign w_unused = ^{i_pc_reg[XLEN-1:2], i_pc_reg[0]};

    rvc_length_decoder u_dec_lo (
        .i_halfword      (i_fetch_word[15:0]),
        .o_is_compressed (w_lo_compressed)
    );

    rvc_length_decoder u_dec_hi (
        .i_halfword      (i_fetch_word[31:16]),
        .o_is_compressed (w_hi_compressed)
    );

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        o_instr                   = i_fetch_word;
        o_instr_valid             = 1'b0;
        o_is_compressed           = 1'b0;
        o_is_32bit_spanning       = 1'b0;
        o_spanning_wait_for_fetch = 1'b0;
        o_spanning_in_progress    = 1'b0;
        o_spanning_to_halfword    = 1'b0;
        case (r_state)
            ALIGN: begin
                if (i_pc_reg[1]) begin
                    o_is_compressed     = w_hi_compressed;
                    o_instr             = {16'h0, i_fetch_word[31:16]};
                    o_is_32bit_spanning = !w_kill && !i_holdoff && !w_hi_compressed;
                end else begin
                    o_is_compressed = w_lo_compressed;
                    o_instr         = w_lo_compressed ? {16'h0, i_fetch_word[15:0]} : i_fetch_word;
                end
                o_instr_valid = !w_kill && !i_holdoff && !o_is_32bit_spanning;
            end
            SPAN_WAIT: begin
                o_spanning_wait_for_fetch = !w_kill;
            end
            SPAN_DONE: begin
                // Upper half of the spanning instruction arrives in the next word's low half.
                o_instr                = {i_fetch_word[15:0], r_span_lo};
                o_spanning_in_progress = !w_kill;
                o_spanning_to_halfword = !w_kill && !i_holdoff;
                o_instr_valid          = !w_kill && !i_holdoff;
            end
            default: ;
        endcase
    end

    // NOTE: reset is synchronous, so it is sampled inside the clocked branch, ahead of flush and stall.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_state         <= ALIGN;
            r_span_lo       <= 16'h0;
            r_is_compressed <= 1'b0;
            r_to_halfword   <= 1'b0;
        end else if (!i_stall) begin
            r_is_compressed <= o_is_compressed;
            r_to_halfword   <= o_spanning_to_halfword;
            case (r_state)
                ALIGN: begin
                    if (o_is_32bit_spanning) begin
                        r_span_lo <= i_fetch_word[31:16];
                        r_state   <= SPAN_WAIT;
                    end
                end
                SPAN_WAIT: if (!i_holdoff) r_state <= SPAN_DONE;
                SPAN_DONE: if (!i_holdoff) r_state <= ALIGN;
                default:   r_state <= ALIGN;
            endcase
        end
    end

    assign o_is_compressed_r                 = r_is_compressed;
    assign o_spanning_to_halfword_registered = r_to_halfword;

`else

    logic w_unused;

    assign w_unused = ^{i_clk, i_stall, i_pc_reg};

    assign o_instr                           = i_fetch_word;
    assign o_instr_valid                     = !i_reset && !i_flush && !i_holdoff;
    assign o_is_compressed                   = 1'b0;
    assign o_is_compressed_r                 = 1'b0;
    assign o_is_32bit_spanning               = 1'b0;
    assign o_spanning_wait_for_fetch         = 1'b0;
    assign o_spanning_in_progress            = 1'b0;
    assign o_spanning_to_halfword            = 1'b0;
    assign o_spanning_to_halfword_registered = 1'b0;

`endif

endmodule

// File: doc/if_instr_aligner.md
IF_INSTR_ALIGNER -- requirements
Module: if_instr_aligner

Interface
REQ-001 SHALL have parameter XLEN, default 32, instruction-address width.
REQ-002 SHALL have i_clk  input  1  clock; i_reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL have i_stall  input  1  hold all state and outputs.
REQ-004 SHALL have i_flush  input  1  discard in-flight alignment.
REQ-005 SHALL have i_holdoff  input  1  fetch word is stale this cycle (any-holdoff from the PC stage).
REQ-006 SHALL have i_pc_reg  input  XLEN  PC of the instruction being aligned.
REQ-007 SHALL have i_fetch_word  input  32  memory word at {i_pc_reg[XLEN-1:2],2'b00}.
REQ-008 SHALL have o_instr  output  32  aligned instruction; compressed instructions are zero-extended in [15:0].
REQ-009 SHALL have o_instr_valid  output  1  o_instr is a complete, non-stale instruction.
REQ-010 SHALL have o_is_compressed  output  1  combinational, halfword[1:0]!=2'b11.
REQ-011 SHALL have o_is_compressed_r  output  1  registered o_is_compressed, for PC increment.
REQ-012 SHALL have o_is_32bit_spanning, o_spanning_wait_for_fetch, o_spanning_in_progress, o_spanning_to_halfword, o_spanning_to_halfword_registered  output  1 each  spanning status to the PC stage.

Function
REQ-013 SHALL implement FSM states ALIGN, SPAN_WAIT, SPAN_DONE; state advances only when !i_stall.
REQ-014 ALIGN, i_pc_reg[1]=0: SHALL take low halfword; compressed -> o_instr={16'h0,word[15:0]}; else o_instr=word; valid=1.
REQ-015 ALIGN, i_pc_reg[1]=1, word[17:16]!=2'b11: SHALL output {16'h0,word[31:16]}, valid=1, compressed=1.
REQ-016 ALIGN, i_pc_reg[1]=1, word[17:16]==2'b11: SHALL assert o_is_32bit_spanning, valid=0, capture word[31:16] into span_lo, go SPAN_WAIT.
REQ-017 SPAN_WAIT: SHALL assert o_spanning_wait_for_fetch, valid=0, go SPAN_DONE next cycle (one cycle of fetch latency).
REQ-018 SPAN_DONE: SHALL output {word[15:0],span_lo}, valid=1, assert o_spanning_in_progress and o_spanning_to_halfword, return to ALIGN.
REQ-019 o_spanning_to_halfword_registered SHALL equal o_spanning_to_halfword delayed one unstalled cycle.
REQ-020 i_holdoff in ALIGN SHALL force valid=0 and all spanning outputs 0, with no state change; i_holdoff in SPAN_WAIT/SPAN_DONE SHALL hold the state.
REQ-021 i_flush SHALL force valid=0, return to ALIGN next cycle, clear span_lo and the registered flags; flush beats stall.
REQ-022 i_stall SHALL freeze state, span_lo, and every registered output; combinational outputs still reflect the current inputs.
REQ-023 o_is_compressed SHALL be 0 in SPAN_WAIT/SPAN_DONE.

Reset
REQ-024 Reset SHALL set state=ALIGN, span_lo=0, o_is_compressed_r=0, o_spanning_to_halfword_registered=0, with o_instr_valid=0 in the reset cycle.
REQ-025 Reset SHALL override stall and flush, including mid-span.

Configuration
REQ-026 With macro FROST_C_EXT_EN defined: behaviour SHALL be as above.
REQ-027 Without it: every instruction SHALL be 32-bit, o_instr=word, i_pc_reg[1] ignored, the FSM removed, and all compressed/spanning outputs tied to 0.

Structure
REQ-028 The aligner_state_e enum and the RVC_OPCODE_FULL=2'b11 constant SHALL live in if_stage_pkg.
REQ-029 A single sub-module, rvc_length_decoder (halfword -> is_compressed), SHALL be instantiated twice, for the low and high halfword.

Verification
REQ-030 pc_reg=0x100, word=0x00A00093 -> o_instr=0x00A00093, valid=1, compressed=0.
REQ-031 pc_reg=0x102, word=0x45011234 -> o_instr=0x00004501, valid=1, compressed=1.
REQ-032 pc_reg=0x106, word=0x0093xxxx, then word=0xxxxx00A0 -> cycle0 spanning=1/valid=0; cycle1 wait_for_fetch=1; cycle2 o_instr=0x00A00093, valid=1, to_halfword=1; cycle3 to_halfword_registered=1.
REQ-033 Span case with i_stall held 3 cycles in SPAN_WAIT -> state and span_lo unchanged; completes 1 cycle after release.
REQ-034 i_flush in SPAN_WAIT -> next cycle ALIGN, valid=0, spanning outputs 0; reset in SPAN_DONE -> ALIGN, valid=0.
REQ-035 Build without FROST_C_EXT_EN, pc_reg=0x102 -> o_instr=word, compressed=0, all spanning outputs 0.
